// File: rtl/data_sram_responder_pkg.sv
// Shared types for the data-SRAM responder: word/lane geometry, read encoding, FSM states.
// Counter-width helper keeps a zero-wait build at a legal 1-bit counter.
package data_sram_responder_pkg;

    localparam int DATA_W = 32;
    localparam int LANES  = 4;

    typedef logic [LANES-1:0]  wen_t;
    typedef logic [DATA_W-1:0] word_t;

    localparam wen_t WEN_READ = 4'b0000;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    function automatic int cnt_width(input int n);
        return (n > 0) ? $clog2(n + 1) : 1;
    endfunction

endpackage

// File: rtl/data_sram_responder_if.sv
// Data-SRAM port between the EX/MEM stages (master) and the memory responder (slave).
interface data_sram_if;
    import data_sram_responder_pkg::*;

    logic        data_sram_en;
    wen_t        data_sram_wen;
    logic [31:0] data_sram_addr;
    word_t       data_sram_wdata;
    word_t       data_sram_rdata;
    logic        stallreq;

    modport master (
        output data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata,
        input  data_sram_rdata, stallreq
    );

    modport slave (
        input  data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata,
        output data_sram_rdata, stallreq
    );

endinterface

// File: rtl/data_sram_responder_dsram_bank.sv
// Byte-lane-writable word array with a registered read port; read register clears on rst,
// the array itself is never cleared.
module dsram_bank
    import data_sram_responder_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  wen_t              wen,
    input  logic [ADDR_W-1:0] idx,
    input  word_t             wdata,
    output word_t             rdata
);

    word_t mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (en) begin
            for (int i = 0; i < LANES; i++) begin
                if (wen[i]) begin
                    mem[idx][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (en && (wen == WEN_READ)) begin
            rdata <= mem[idx];
        end
    end

endmodule

// File: rtl/data_sram_responder.sv
// Data-SRAM responder: accepts one access per idle cycle, optional wait states when
// DSRAM_WAIT_EN is defined (WAIT_CYCLES per access, signalled through stallreq).
module data_sram_responder
    import data_sram_responder_pkg::*;
#(
    parameter int ADDR_W      = 10,
    parameter int WAIT_CYCLES = 0
) (
    input  logic         clk,
    input  logic         rst,
    data_sram_if.slave   bus
);

    logic              accept;
    logic              is_read;
    logic [ADDR_W-1:0] idx;
    word_t             hold;
    word_t             rdata_out;
    logic              stall;
    logic              unused_addr_bits;

    assign idx              = bus.data_sram_addr[ADDR_W+1:2];
    assign unused_addr_bits = ^{bus.data_sram_addr[31:ADDR_W+2], bus.data_sram_addr[1:0]};
    assign is_read          = (bus.data_sram_wen == WEN_READ);

    // The bank's read register doubles as the hold register.
    dsram_bank #(.ADDR_W(ADDR_W)) u_bank (
        .clk   (clk),
        .rst   (rst),
        .en    (accept),
        .wen   (bus.data_sram_wen),
        .idx   (idx),
        .wdata (bus.data_sram_wdata),
        .rdata (hold)
    );

`ifdef DSRAM_WAIT_EN
    localparam int                CNT_W    = cnt_width(WAIT_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(WAIT_CYCLES);

    state_e           state;
    state_e           state_nxt;
    logic [CNT_W-1:0] cnt;

    assign accept = bus.data_sram_en && (state == ST_IDLE) && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                cnt <= CNT_LOAD;
            end else if (state == ST_BUSY) begin
                cnt <= cnt - CNT_W'(1);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (accept && (WAIT_CYCLES > 0)) state_nxt = ST_BUSY;
            ST_BUSY: if (cnt == CNT_W'(1))            state_nxt = ST_IDLE;
            default:                                  state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        stall = (state == ST_BUSY);
    end

    generate
        if (WAIT_CYCLES == 0) begin : g_no_wait
            assign rdata_out = hold;
        end else begin : g_wait
            word_t rdata_q;
            logic  rd_pend;
            logic  done;

            // Completion is the edge on which the counter reaches zero.
            assign done = (state == ST_BUSY) && (cnt == CNT_W'(1));

            always_ff @(posedge clk) begin
                if (rst) begin
                    rdata_q <= '0;
                    rd_pend <= 1'b0;
                end else begin
                    if (accept) begin
                        rd_pend <= is_read;
                    end else if (done) begin
                        rd_pend <= 1'b0;
                    end
                    if (done && rd_pend) begin
                        rdata_q <= hold;
                    end
                end
            end

            assign rdata_out = rdata_q;
        end
    endgenerate
`else
    logic unused_wait_cfg;

    assign unused_wait_cfg = (WAIT_CYCLES != 0) ^ is_read;
    assign accept          = bus.data_sram_en && !rst;
    assign stall           = 1'b0;
    assign rdata_out       = hold;
`endif

    assign bus.data_sram_rdata = rdata_out;
    assign bus.stallreq        = stall;

endmodule

// File: doc/data_sram_responder.md
# data_sram_responder

Responder end of the CPU data-SRAM port: consumes the enable/byte-write-enable/address/write-data request the EX stage drives and returns read data that the MEM stage samples one cycle later. Holds a byte-lane word array and optionally inserts wait states, signalling them through a stall request into the pipeline stall controller. Sits beside the core as the simulation/FPGA data memory.

## Interface
- ADDR_W, 10, word-address bits; the array holds 2^ADDR_W 32-bit words.
- WAIT_CYCLES, 0, extra cycles per access; used only when DSRAM_WAIT_EN is defined.

- clk  in  1  clock
- rst  in  1  reset rst, synchronous, active-high; clock clk
- data_sram_en  in  1  access request this cycle
- data_sram_wen  in  4  byte write enables, bit i = byte lane i (bits 8i+7:8i); 0000 = read
- data_sram_addr  in  32  byte address
- data_sram_wdata  in  32  write data, lane-aligned
- data_sram_rdata  out  32  registered read data
- stallreq  out  1  responder busy; pipeline must hold

## Operation
- Word index = data_sram_addr[ADDR_W+1:2]; addr[1:0] and bits above ADDR_W+1 ignored.
- Accept: rising edge with data_sram_en=1 and state IDLE. Requests while BUSY are ignored (requester re-presents them after stallreq drops).
- Write (wen≠0): lanes with wen[i]=1 written at the accepting edge; other lanes unchanged. data_sram_rdata unchanged by writes.
- Read (wen=0): word read at the accepting edge into hold register; copied to data_sram_rdata on completion.
- data_sram_rdata holds its value through idle cycles, writes and BUSY until the next read completes.
- Read of a word written at an earlier edge returns the new data (no stale read).
- FSM: IDLE → (accept, N>0) BUSY → (count reaches 0) IDLE. With N=0, no BUSY state; completion coincides with acceptance.
- Counter: loaded with WAIT_CYCLES at acceptance, decrements each edge in BUSY; width $clog2(WAIT_CYCLES+1), minimum 1.
- stallreq = (state == BUSY), registered-state derived; asserted for exactly WAIT_CYCLES cycles after an accepted access, reads and writes alike.
- Reset: state IDLE, counter 0, stallreq 0, data_sram_rdata 0, hold register 0. Array contents not cleared (X until written).
- Reset during BUSY: pending read discarded, stallreq 0 from the next cycle; a write already accepted stays committed.

## Timing
- Request presented in cycle t, accepted at edge ending t.
- Without wait states: rdata valid in cycle t+1, matching MEM sampling; stallreq never asserted.
- With N wait states: stallreq=1 in cycles t+1..t+N; rdata updated at edge ending t+N, valid in t+N+1 with stallreq=0.
- Back-to-back accesses with N=0: one per cycle, no bubbles.
- With N>0: next acceptance no earlier than the edge ending cycle t+N+1, throughput 1 access per N+1 cycles.

## Configuration
- DSRAM_WAIT_EN defined: WAIT_CYCLES honoured, counter/FSM built, stallreq driven as above.
- DSRAM_WAIT_EN undefined: WAIT_CYCLES ignored, no counter/FSM, stallreq tied 0, fixed 1-cycle read latency; functionally identical to defined with WAIT_CYCLES=0.

## Structure
- Shared package/defines header: data word width (32), byte-lane count (4), read encoding (wen=0000), state encodings IDLE/BUSY.
- One sub-module: dsram_bank — 2^ADDR_W × 32 byte-lane-writable array with synchronous read port; the responder wraps it with acceptance logic, hold register, counter and FSM.

## Test plan
- Macro off: write 0x12345678 wen=1111 addr 0x10, then read addr 0x10 → rdata=0x12345678 the cycle after the read, stallreq stays 0.
- Byte lanes: preload 0xFFFFFFFF at 0x20, write 0x000000AB wen=0001, then 0x00CD0000 wen=0100, read → 0xFFCDFFAB.
- Aliasing: ADDR_W=10, write 0xDEADBEEF at 0x0000_0004, read 0x0000_1004 and 0x0000_0006 → both 0xDEADBEEF.
- Macro on, WAIT_CYCLES=2: read accepted cycle t → stallreq=1 in t+1,t+2, rdata new value in t+3 with stallreq=0; requests re-presented in t+1,t+2 ignored.
- Macro on, WAIT_CYCLES=3: rst pulsed in the second BUSY cycle → stallreq 0 and rdata 0 next cycle; earlier accepted write to 0x30 readable afterwards.
- Back-to-back, macro off: reads of 0x40,0x44,0x48 in consecutive cycles → rdata returns each word on successive cycles; rdata holds last value during following idle cycles.
